// File: rtl/ex_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: radix-2 shift-add MUL, restoring DIV, one bit per cycle.
// Results land in HI/LO DATA_W edges after accept (divide-by-zero: next edge); stall_o holds the pipe meanwhile.
module ex_muldiv #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] HILO_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              flush_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] hilo_wdata_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_zero_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned   CW   = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic                dz_q, dz_d;

  logic                sgn, sa, sb;
  logic [DATA_W-1:0]   ma, mb;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] mul_next, div_next, prod;
  logic [DATA_W-1:0]   quo, rem;

  // Datapath: acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    sgn       = ~op_i[0];
    sa        = sgn & opa_i[DATA_W-1];
    sb        = sgn & opb_i[DATA_W-1];
    ma        = sa ? -opa_i : opa_i;
    mb        = sb ? -opb_i : opb_i;
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    div_shift = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, b_q};
    div_next  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                 : {div_diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};
    prod      = neg_lo_q ? -mul_next : mul_next;
    quo       = neg_lo_q ? -div_next[DATA_W-1:0] : div_next[DATA_W-1:0];
    rem       = neg_hi_q ? -div_next[2*DATA_W-1:DATA_W] : div_next[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = 1'b0;

    // MTHI/MTLO land first so a commit on the same edge overrides them.
    if (state_q == IDLE || state_q == DONE) begin
      if (hi_we_i) hi_d = hilo_wdata_i;
      if (lo_we_i) lo_d = hilo_wdata_i;
    end

    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          b_d      = mb;
          acc_d    = {{DATA_W{1'b0}}, ma};
          cnt_d    = '0;
          neg_lo_d = sa ^ sb;
          neg_hi_d = sa;
          if (op_i[1] && opb_i == '0) begin
            state_d = DONE;
            hi_d    = opa_i;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d = op_i[1] ? DIV : MUL;
          end
        end
      end
      MUL: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d      = DONE;
            {hi_d, lo_d} = prod;
          end
        end
      end
      DIV: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            hi_d    = rem;
            lo_d    = quo;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      hi_q     <= HILO_RST;
      lo_q     <= HILO_RST;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
    end
  end

  assign busy_o     = (state_q == MUL) || (state_q == DIV);
  assign done_o     = (state_q == DONE);
  assign div_zero_o = dz_q;
  assign stall_o    = rst_n & (busy_o | ((state_q == IDLE) & start_i & ~flush_i));
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv (DATA_W=32): vector table plus reference-arithmetic model, scoreboard queue, flush/reset sequences.
module tb_ex_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0, flush_i = 1'b0, hi_we_i = 1'b0, lo_we_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] opa_i = '0, opb_i = '0, hilo_wdata_i = '0;
  logic         stall_o, busy_o, done_o, div_zero_o;
  logic [W-1:0] hi_o, lo_o;

  ex_muldiv #(.DATA_W(W), .HILO_RST('0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
    .flush_i(flush_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .hilo_wdata_i(hilo_wdata_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dz;
    int           lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or scoreboard empty", name);
  endtask

  // Reference result {div_zero, hi, lo} from native 64-bit arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa_l, sb_l, r_l;
    logic [63:0]  p;
    logic [W-1:0] q, rr;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    if (op == 2'b00) begin
      r_l = sa_l * sb_l;
      p   = r_l;
      return {1'b0, p};
    end
    if (op == 2'b01) begin
      p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (op == 2'b10) begin
      r_l = sa_l / sb_l; p = r_l; q  = p[W-1:0];
      r_l = sa_l % sb_l; p = r_l; rr = p[W-1:0];
    end else begin
      q  = a / b;
      rr = a % b;
    end
    return {1'b0, rr, q};
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    return v;
  endfunction

  task automatic push_exp(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz;
    e.lat = dz ? 1 : W + 1;
    sbq.push_back(e);
  endtask

  // Presents an instruction at a negedge and holds start through the stall, like the EX stage does.
  task automatic drive_op(input vec_t v, input bit with_mthi);
    push_exp(v.hi, v.lo, v.dz);
    @(negedge clk);
    op_i = v.op; opa_i = v.a; opb_i = v.b; start_i = 1'b1;
    if (with_mthi) begin
      hi_we_i = 1'b1;
      hilo_wdata_i = 32'h0000_ABCD;
    end
    #1 chk("stall_accept", 64'(stall_o), 64'd1);
    @(posedge clk);
    #1;
    if (with_mthi) begin
      hi_we_i = 1'b0;
      chk("mthi_with_start", 64'(hi_o), 64'h0000_ABCD);
    end
  endtask

  task automatic wait_done(input bit flush_in_done);
    exp_t e;
    int   cyc;
    bit   seen, stall_ok;
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done_o) seen = 1'b1;
      else if (!(stall_o && busy_o)) stall_ok = 1'b0;
    end
    if (!seen) begin
      fail_now("done_timeout");
      start_i = 1'b0;
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    if (sbq.size() == 0) begin
      fail_now("scoreboard_empty");
      start_i = 1'b0;
      return;
    end
    e = sbq.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("hi", 64'(hi_o), 64'(e.hi));
    chk("lo", 64'(lo_o), 64'(e.lo));
    chk("div_zero", 64'(div_zero_o), 64'(e.dz));
    chk("stall_in_done", 64'(stall_o), 64'd0);
    chk("stall_while_busy", 64'(stall_ok), 64'd1);
    if (flush_in_done) flush_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    chk("idle_after_done", 64'({busy_o, done_o, div_zero_o}), 64'd0);
    if (flush_in_done) begin
      chk("hi_kept_after_done_flush", 64'(hi_o), 64'(e.hi));
      chk("lo_kept_after_done_flush", 64'(lo_o), 64'(e.lo));
    end
  endtask

  // Preload HI/LO, start MULT, then kill it mid-iteration by flush or by reset.
  task automatic abort_seq(input bit use_rst);
    bit seen;
    @(negedge clk); hi_we_i = 1'b1; hilo_wdata_i = 32'h11;
    @(negedge clk); hi_we_i = 1'b0; lo_we_i = 1'b1; hilo_wdata_i = 32'h22;
    @(negedge clk); lo_we_i = 1'b0;
    chk("preload_hi", 64'(hi_o), 64'h11);
    chk("preload_lo", 64'(lo_o), 64'h22);
    op_i = 2'b00; opa_i = 32'd5; opb_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) begin
      rst_n = 1'b0;
    end else begin
      flush_i = 1'b1;
      hi_we_i = 1'b1;
      hilo_wdata_i = 32'h99;
    end
    @(posedge clk);
    #1 flush_i = 1'b0;
    hi_we_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk(use_rst ? "abort_rst_busy" : "abort_flush_busy", 64'(busy_o), 64'd0);
    chk(use_rst ? "abort_rst_hi" : "abort_flush_hi", 64'(hi_o), use_rst ? 64'd0 : 64'h11);
    chk(use_rst ? "abort_rst_lo" : "abort_flush_lo", 64'(lo_o), use_rst ? 64'd0 : 64'h22);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || div_zero_o) seen = 1'b1;
    end
    chk(use_rst ? "no_done_after_rst" : "no_done_after_flush", 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0));
    tbl.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0));
    tbl.push_back(mk(2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    tbl.push_back(mk(2'b11, 32'h7,         32'h2, 32'h1,         32'h3,         1'b0));
    tbl.push_back(mk(2'b11, 32'h7,         32'h0, 32'h7,         32'hFFFF_FFFF, 1'b1));
    tbl.push_back(mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0));
    tbl.push_back(mk(2'b10, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1));
    tbl.push_back(mk(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0));
    tbl.push_back(mk(2'b10, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0));
    for (int i = 0; i < 6; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      logic [2*W:0] r;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      r  = model(op, a, b);
      tbl.push_back(mk(op, a, b, r[2*W-1:W], r[W-1:0], r[2*W]));
    end

    // Reset state, with an instruction already waiting in EX.
    op_i = 2'b01; opa_i = 32'd3; opb_i = 32'd5; start_i = 1'b1;
    #22;
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_dz", 64'(div_zero_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'd0, 32'd15, 1'b0);
    @(posedge clk);
    #1 chk("first_edge_accept", 64'(busy_o), 64'd1);
    wait_done(1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_op(tbl[i], 1'b0);
      wait_done(i == 2);
    end

    drive_op(mk(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0), 1'b1);
    wait_done(1'b0);

    @(negedge clk);
    op_i = 2'b00; opa_i = 32'd9; opb_i = 32'd9; start_i = 1'b1; flush_i = 1'b1;
    #1 chk("flush_start_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1 start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_start_no_busy", 64'({busy_o, done_o}), 64'd0);

    abort_seq(1'b0);
    abort_seq(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand width; the legal range is even values 8..64.
REQ-002 The block SHALL have parameter HILO_RST, default 0, giving the reset value of the HI and LO registers.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: an EX-stage mul/div instruction is present.
REQ-006 The block SHALL have port op_i, input, 2 bits: operation select, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The block SHALL have ports opa_i and opb_i, inputs, DATA_W bits each: operand A (rs), and operand B (rs's partner rt / divisor).
REQ-008 The block SHALL have port flush_i, input, 1 bit: exception or pipeline flush.
REQ-009 The block SHALL have ports hi_we_i and lo_we_i, inputs, 1 bit each: MTHI and MTLO write enables.
REQ-010 The block SHALL have port hilo_wdata_i, input, DATA_W bits: MTHI/MTLO write data.
REQ-011 The block SHALL have port stall_o, output, 1 bit: pipeline stall request; combinational.
REQ-012 The block SHALL have port busy_o, output, 1 bit: the iteration is in progress; registered.
REQ-013 The block SHALL have port done_o, output, 1 bit: one-cycle pulse meaning the result is committed.
REQ-014 The block SHALL have port div_zero_o, output, 1 bit: pulse that accompanies done_o when the divisor was 0.
REQ-015 The block SHALL have ports hi_o and lo_o, outputs, DATA_W bits each: the HI and LO register contents (MFHI/MFLO source).

Function
REQ-016 The FSM SHALL have states IDLE, MUL, DIV and DONE, and SHALL hold a ceil(log2(DATA_W))-bit iteration counter.
REQ-017 In IDLE, start_i=1 with flush_i=0 SHALL latch the operands and op_i and SHALL move to MUL (op_i[1]=0) or to DIV (op_i[1]=1), with counter=0.
REQ-018 The signed ops (MULT, DIV) SHALL iterate on the operand magnitudes; the result sign SHALL be applied when the result is committed.
REQ-019 MUL SHALL perform radix-2 shift-add, one bit per cycle, for DATA_W cycles, then move to DONE.
REQ-020 DIV SHALL perform radix-2 restoring division, one quotient bit per cycle, for DATA_W cycles, then move to DONE.
REQ-021 The DIV sign rules SHALL be: quotient sign = signA XOR signB; remainder sign = signA.
REQ-022 The MUL result SHALL be committed as {HI,LO} = the full 2*DATA_W-bit product.
REQ-023 The DIV result SHALL be committed as LO = quotient and HI = remainder.
REQ-024 HI and LO SHALL be written on the same edge that enters DONE.
REQ-025 Latency: if start is accepted on edge E0, HI/LO SHALL update on edge E(DATA_W), and done_o SHALL be high for exactly the following cycle.
REQ-026 Divide by zero: DIV/DIVU with opb_i=0 SHALL go IDLE->DONE directly with HI=opa_i and LO=all ones, and SHALL assert div_zero_o with done_o.
REQ-027 Signed DIV of most-negative / -1 SHALL give LO = most-negative (wrap) and HI = 0, with no error flag.
REQ-028 In DONE, start_i SHALL be ignored (the same instruction is still in EX), and the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-029 busy_o SHALL be 1 in MUL and DIV, and 0 in IDLE and DONE.
REQ-030 stall_o SHALL equal busy_o OR (state==IDLE AND start_i AND NOT flush_i).
REQ-031 flush_i=1 in MUL or DIV SHALL abort to IDLE on the next edge: HI/LO unchanged, no done_o, no div_zero_o.
REQ-032 flush_i=1 in DONE SHALL NOT undo HI/LO, which are already committed.
REQ-033 flush_i and start_i both high in IDLE: flush SHALL win and no operation SHALL start.
REQ-034 hi_we_i or lo_we_i SHALL write hilo_wdata_i to HI or LO only in IDLE or DONE, and SHALL be ignored in MUL and DIV.
REQ-035 A write with start_i in IDLE: the write SHALL take effect, and the later commit SHALL overwrite it.
REQ-036 hi_o and lo_o SHALL always reflect the registers directly, with no bypass of in-flight results.

Reset
REQ-037 When rst_n=0, the block SHALL asynchronously force: state=IDLE, counter=0, busy_o=0, done_o=0, div_zero_o=0, HI=LO=HILO_RST, and internal operand/accumulator registers to 0.
REQ-038 While rst_n=0, stall_o SHALL evaluate to 0.
REQ-039 Reset asserted mid-operation SHALL abandon the operation, with no done_o after release.
REQ-040 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (DATA_W=32)
REQ-041 MULT opa=0xFFFFFFFF, opb=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; done_o high in cycle 33 after the accept edge; stall_o high cycles 0..32.
REQ-042 MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-043 DIV opa=0xFFFFFFF9 (-7), opb=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU opa=7, opb=2 -> LO=3, HI=1.
REQ-044 DIVU opa=7, opb=0 -> done_o and div_zero_o in the cycle after accept; HI=0x7, LO=0xFFFFFFFF.
REQ-045 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; no div_zero_o.
REQ-046 HI=0x11, LO=0x22 preloaded via MTHI/MTLO; MULT started, then flush_i at iteration 10 -> IDLE the next cycle, no done_o, HI=0x11, LO=0x22; the same sequence with rst_n pulsed low instead of flush_i -> HI=LO=0.
